// File: rtl/common_pkg.sv
// Shared widths, bus payload and arbiter state type for the video Wishbone fabric.
package common_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 24;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned OUTST_WIDTH   = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2,
        ARB_DRAIN  = 2'd3
    } arb_state_t;

    // Request payload forwarded from the granted controller to the peripheral.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        logic                     we;
    } wb_req_t;

endpackage

// File: rtl/wb_outstanding_counter.sv
// Counts accepted-but-unacknowledged Wishbone strobes; never underflows.
module wb_outstanding_counter
    import common_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   wb_clock_i,
    input  logic                   reset_i,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   clear,
    output logic [OUTST_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    // Simultaneous inc and dec cancel; a dec at zero is a stray ack and is dropped.
    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + OUTST_WIDTH'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - OUTST_WIDTH'(1);
        end
    end

    // Occupancy flags used by the arbiter for stalling and release.
    always_comb begin
        full  = (count == OUTST_WIDTH'(MAX_OUTSTANDING));
        empty = (count == '0);
    end

endmodule

// File: rtl/video_wb_arbiter.sv
// Two-controller Wishbone B4 pipelined arbiter: port 0 = video fetch, port 1 = MCU/SPI bridge.
// Optional macro WB_ARBITER_ROUND_ROBIN_EN: ties go to the port not granted most recently
// (default build: port 0 always wins ties).
module video_wb_arbiter
    import common_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     wb_clock_i,
    input  logic                     reset_i,

    input  logic [WB_ADDR_WIDTH-1:0] wb0_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb0_data_i,
    output logic [DATA_WIDTH-1:0]    wb0_data_o,
    input  logic                     wb0_we_i,
    input  logic                     wb0_cycle_i,
    input  logic                     wb0_strobe_i,
    output logic                     wb0_stall_o,
    output logic                     wb0_ack_o,

    input  logic [WB_ADDR_WIDTH-1:0] wb1_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb1_data_i,
    output logic [DATA_WIDTH-1:0]    wb1_data_o,
    input  logic                     wb1_we_i,
    input  logic                     wb1_cycle_i,
    input  logic                     wb1_strobe_i,
    output logic                     wb1_stall_o,
    output logic                     wb1_ack_o,

    output logic [WB_ADDR_WIDTH-1:0] wbp_addr_o,
    output logic [DATA_WIDTH-1:0]    wbp_data_o,
    output logic                     wbp_we_o,
    output logic                     wbp_cycle_o,
    output logic                     wbp_strobe_o,
    input  logic [DATA_WIDTH-1:0]    wbp_data_i,
    input  logic                     wbp_stall_i,
    input  logic                     wbp_ack_i
);

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [OUTST_WIDTH-1:0] outst_count;
    logic                   outst_full;
    logic                   outst_empty;
    logic                   tie_to_port1;
    wb_req_t                req0;
    wb_req_t                req1;
    wb_req_t                req_fwd;

    // Read data is broadcast; only the granted controller sees an ack.
    assign wb0_data_o = wbp_data_i;
    assign wb1_data_o = wbp_data_i;

    assign req0 = '{addr: wb0_addr_i, data: wb0_data_i, we: wb0_we_i};
    assign req1 = '{addr: wb1_addr_i, data: wb1_data_i, we: wb1_we_i};

    assign wbp_addr_o = req_fwd.addr;
    assign wbp_data_o = req_fwd.data;
    assign wbp_we_o   = req_fwd.we;

    // Outstanding-request tracker shared by whichever controller holds the grant.
    wb_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outst (
        .wb_clock_i (wb_clock_i),
        .reset_i    (reset_i),
        .inc        (wbp_strobe_o && !wbp_stall_i),
        .dec        (wbp_ack_i),
        .clear      (state_q == ARB_IDLE),
        .count      (outst_count),
        .full       (outst_full),
        .empty      (outst_empty)
    );

`ifdef WB_ARBITER_ROUND_ROBIN_EN
    logic last_grant_q;

    // Remember which port was granted last; resets to port 1 so the first tie favours video.
    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant_q <= 1'b1;
        end else if (state_q == ARB_IDLE && state_d == ARB_GRANT0) begin
            last_grant_q <= 1'b0;
        end else if (state_q == ARB_IDLE && state_d == ARB_GRANT1) begin
            last_grant_q <= 1'b1;
        end
    end

    assign tie_to_port1 = !last_grant_q;
`else
    assign tie_to_port1 = 1'b0;
`endif

    // Arbiter state register.
    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and combinational pass-through of the granted controller.
    always_comb begin
        state_d      = state_q;
        req_fwd      = '0;
        wbp_cycle_o  = 1'b0;
        wbp_strobe_o = 1'b0;
        wb0_stall_o  = 1'b1;
        wb1_stall_o  = 1'b1;
        wb0_ack_o    = 1'b0;
        wb1_ack_o    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (wb0_cycle_i && wb1_cycle_i) begin
                    state_d = tie_to_port1 ? ARB_GRANT1 : ARB_GRANT0;
                end else if (wb0_cycle_i) begin
                    state_d = ARB_GRANT0;
                end else if (wb1_cycle_i) begin
                    state_d = ARB_GRANT1;
                end
            end

            ARB_GRANT0: begin
                req_fwd      = req0;
                wbp_cycle_o  = wb0_cycle_i;
                wbp_strobe_o = wb0_strobe_i && !outst_full;
                wb0_stall_o  = wbp_stall_i || outst_full;
                wb0_ack_o    = wbp_ack_i;
                if (!wb0_cycle_i) begin
                    state_d = outst_empty ? ARB_IDLE : ARB_DRAIN;
                end
            end

            ARB_GRANT1: begin
                req_fwd      = req1;
                wbp_cycle_o  = wb1_cycle_i;
                wbp_strobe_o = wb1_strobe_i && !outst_full;
                wb1_stall_o  = wbp_stall_i || outst_full;
                wb1_ack_o    = wbp_ack_i;
                if (!wb1_cycle_i) begin
                    state_d = outst_empty ? ARB_IDLE : ARB_DRAIN;
                end
            end

            ARB_DRAIN: begin
                // Hold the bus until abandoned transfers are acked; those acks go nowhere.
                wbp_cycle_o = 1'b1;
                if (outst_count == '0) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Randomized self-checking bench for video_wb_arbiter against a behavioural ownership model.
module tb_video_wb_arbiter;
    import common_pkg::*;

    localparam int unsigned MAXO  = 2;
    localparam int unsigned AW    = WB_ADDR_WIDTH;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int          NCYC  = 4000;
    localparam int          OWN_NONE  = -1;
    localparam int          OWN_DRAIN = 2;

    logic          wb_clock_i = 1'b0;
    logic          reset_i;
    logic [AW-1:0] wb0_addr_i, wb1_addr_i, wbp_addr_o;
    logic [DW-1:0] wb0_data_i, wb1_data_i, wb0_data_o, wb1_data_o;
    logic [DW-1:0] wbp_data_o, wbp_data_i;
    logic          wb0_we_i, wb1_we_i, wb0_cycle_i, wb1_cycle_i;
    logic          wb0_strobe_i, wb1_strobe_i, wb0_stall_o, wb1_stall_o;
    logic          wb0_ack_o, wb1_ack_o;
    logic          wbp_we_o, wbp_cycle_o, wbp_strobe_o, wbp_stall_i, wbp_ack_i;

    always #5 wb_clock_i = ~wb_clock_i;

    video_wb_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .wb_clock_i   (wb_clock_i),
        .reset_i      (reset_i),
        .wb0_addr_i   (wb0_addr_i),
        .wb0_data_i   (wb0_data_i),
        .wb0_data_o   (wb0_data_o),
        .wb0_we_i     (wb0_we_i),
        .wb0_cycle_i  (wb0_cycle_i),
        .wb0_strobe_i (wb0_strobe_i),
        .wb0_stall_o  (wb0_stall_o),
        .wb0_ack_o    (wb0_ack_o),
        .wb1_addr_i   (wb1_addr_i),
        .wb1_data_i   (wb1_data_i),
        .wb1_data_o   (wb1_data_o),
        .wb1_we_i     (wb1_we_i),
        .wb1_cycle_i  (wb1_cycle_i),
        .wb1_strobe_i (wb1_strobe_i),
        .wb1_stall_o  (wb1_stall_o),
        .wb1_ack_o    (wb1_ack_o),
        .wbp_addr_o   (wbp_addr_o),
        .wbp_data_o   (wbp_data_o),
        .wbp_we_o     (wbp_we_o),
        .wbp_cycle_o  (wbp_cycle_o),
        .wbp_strobe_o (wbp_strobe_o),
        .wbp_data_i   (wbp_data_i),
        .wbp_stall_i  (wbp_stall_i),
        .wbp_ack_i    (wbp_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Controller stimulus state, one entry per port.
    logic          c   [2];
    logic          s   [2];
    logic          we  [2];
    logic [AW-1:0] a   [2];
    logic [DW-1:0] d   [2];
    logic          acc [2];

    // Model: who owns the bus, how many transfers are in flight, who was granted last.
    int m_owner, m_outst, m_last;
    int n_owner, n_outst, n_last;
    int ties_seen, aborts_seen;

    task automatic new_req(input int k);
        s[k]  = ($urandom_range(0, 3) != 0);
        we[k] = 1'($urandom_range(0, 1));
        a[k]  = AW'($urandom);
        d[k]  = DW'($urandom);
    endtask

    task automatic drive_ports();
        wb0_cycle_i = c[0]; wb0_strobe_i = s[0]; wb0_we_i = we[0];
        wb0_addr_i  = a[0]; wb0_data_i   = d[0];
        wb1_cycle_i = c[1]; wb1_strobe_i = s[1]; wb1_we_i = we[1];
        wb1_addr_i  = a[1]; wb1_data_i   = d[1];
    endtask

    // Compare DUT outputs with the model for this cycle, then derive the model's next cycle.
    task automatic eval_cycle();
        logic          e_cyc, e_stb, e_we, e_full, e_acc;
        logic          e_stall [2];
        logic          e_ack   [2];
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        int            win;

        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        e_stall[0] = 1'b1; e_stall[1] = 1'b1; e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_full = (m_outst == int'(MAXO));

        if (m_owner == 0 || m_owner == 1) begin
            e_cyc  = c[m_owner];
            e_stb  = s[m_owner] && !e_full;
            e_we   = we[m_owner];
            e_addr = a[m_owner];
            e_data = d[m_owner];
            e_stall[m_owner] = wbp_stall_i || e_full;
            e_ack[m_owner]   = wbp_ack_i;
        end else if (m_owner == OWN_DRAIN) begin
            e_cyc = 1'b1;
        end

        check("wbp_cycle",  64'(wbp_cycle_o),  64'(e_cyc));
        check("wbp_strobe", 64'(wbp_strobe_o), 64'(e_stb));
        check("wb0_stall",  64'(wb0_stall_o),  64'(e_stall[0]));
        check("wb1_stall",  64'(wb1_stall_o),  64'(e_stall[1]));
        check("wb0_ack",    64'(wb0_ack_o),    64'(e_ack[0]));
        check("wb1_ack",    64'(wb1_ack_o),    64'(e_ack[1]));
        check("wb0_rdata",  64'(wb0_data_o),   64'(wbp_data_i));
        check("wb1_rdata",  64'(wb1_data_o),   64'(wbp_data_i));
        if (m_owner != OWN_DRAIN) begin
            check("wbp_we",   64'(wbp_we_o),   64'(e_we));
            check("wbp_addr", 64'(wbp_addr_o), 64'(e_addr));
            check("wbp_data", 64'(wbp_data_o), 64'(e_data));
        end

        e_acc  = e_stb && !wbp_stall_i;
        acc[0] = e_acc && (m_owner == 0);
        acc[1] = e_acc && (m_owner == 1);

        n_outst = m_outst;
        if (e_acc && !wbp_ack_i)               n_outst = m_outst + 1;
        else if (!e_acc && wbp_ack_i && m_outst > 0) n_outst = m_outst - 1;

        n_owner = m_owner;
        n_last  = m_last;
        if (m_owner == OWN_NONE) begin
            win = OWN_NONE;
            if (c[0] && c[1]) begin
                ties_seen++;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
                win = (m_last == 1) ? 0 : 1;
`else
                win = 0;
`endif
            end else if (c[0]) begin
                win = 0;
            end else if (c[1]) begin
                win = 1;
            end
            if (win != OWN_NONE) begin
                n_owner = win;
                n_last  = win;
            end
        end else if (m_owner == OWN_DRAIN) begin
            if (m_outst == 0) n_owner = OWN_NONE;
        end else if (!c[m_owner]) begin
            if (m_outst > 0) aborts_seen++;
            n_owner = (m_outst == 0) ? OWN_NONE : OWN_DRAIN;
        end
    endtask

    task automatic model_reset();
        m_owner = OWN_NONE; m_outst = 0; m_last = 1;
        acc[0] = 1'b0; acc[1] = 1'b0;
    endtask

    initial begin
        logic rst_now;
        ties_seen = 0; aborts_seen = 0;
        for (int k = 0; k < 2; k++) begin
            c[k] = 1'b0; s[k] = 1'b0; we[k] = 1'b0; a[k] = '0; d[k] = '0;
        end
        reset_i = 1'b1;
        wbp_stall_i = 1'b0; wbp_ack_i = 1'b0; wbp_data_i = '0;
        drive_ports();
        model_reset();

        repeat (2) @(posedge wb_clock_i);
        @(negedge wb_clock_i);
        eval_cycle();
        #1 reset_i = 1'b0;

        for (int i = 0; i < NCYC; i++) begin
            @(posedge wb_clock_i);
            #1;
            m_owner = n_owner; m_outst = n_outst; m_last = n_last;

            // Controllers: hold a stalled strobe, otherwise issue, idle, or drop the cycle.
            if (!c[0] && !c[1] && $urandom_range(0, 2) == 0) begin
                c[0] = 1'b1; c[1] = 1'b1; new_req(0); new_req(1);
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (!c[k]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            c[k] = 1'b1; new_req(k);
                        end
                    end else if (s[k] && !acc[k]) begin
                        s[k] = s[k];
                    end else if ($urandom_range(0, 9) == 0) begin
                        c[k] = 1'b0; s[k] = 1'b0;
                    end else begin
                        new_req(k);
                    end
                end
            end
            drive_ports();

            // Peripheral: random stall, acks only while work is pending plus rare stray acks.
            wbp_stall_i = ($urandom_range(0, 3) == 0);
            wbp_ack_i   = (m_outst > 0) ? ($urandom_range(0, 2) != 0)
                                        : ($urandom_range(0, 11) == 0);
            wbp_data_i  = DW'($urandom);

            rst_now = (i > 20) && ($urandom_range(0, 149) == 0);
            if (rst_now) begin
                #2 reset_i = 1'b1;
                #2 model_reset();
            end else begin
                #4;
            end

            eval_cycle();
            if (rst_now) #2 reset_i = 1'b0;
        end

        check("ties_exercised",   64'(ties_seen > 0),   64'(1));
        check("aborts_exercised", 64'(aborts_seen > 0), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
